// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the CPU reset controller.
// FSM state encodings and default timing parameters.
package cpu_ctrl_pkg;

  localparam logic [1:0] POR      = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;
  localparam logic [1:0] WAIT_REL = 2'd3;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_HOLD_CYCLES     = 16;
  localparam int DEF_POR_CYCLES      = 64;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser and stability counter for the reset button.
// key_db only follows the key after DEBOUNCE_CYCLES stable samples.
module key_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_50,
  input  logic reset,
  input  logic key_n,
  output logic key_db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic          db_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any sample agreeing with the accepted level restarts the count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_db = db_q;

endmodule

// File: rtl/cpu_reset_ctrl.sv
// Clean reset generator for the CPU clock divider: power-on hold,
// debounced button resets of guaranteed minimum width, press counter.
module cpu_reset_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int POR_CYCLES      = DEF_POR_CYCLES
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       key_n,
  output logic       resetn,
  output logic       key_db,
  output logic [7:0] reset_count
);

  localparam int TMAX = (HOLD_CYCLES > POR_CYCLES) ? HOLD_CYCLES : POR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] POR_LAST  = TW'(POR_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [TW-1:0] tcnt_q;
  logic [TW-1:0] tcnt_d;
  logic [7:0]    rc_q;
  logic [7:0]    rc_d;
  logic          db_prev_q;
  logic          resetn_q;
  logic          db;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk_50(clk_50),
    .reset (reset),
    .key_n (key_n),
    .key_db(db)
  );

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    rc_d    = rc_q;
    case (state_q)
      POR: begin
        if (tcnt_q == POR_LAST) begin
          tcnt_d  = '0;
          state_d = db ? RUN : WAIT_REL;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RUN: begin
        if (db_prev_q && !db) begin
          state_d = HOLD;
          tcnt_d  = '0;
          rc_d    = rc_q + 1'b1;
        end
      end
      HOLD: begin
        if (tcnt_q == HOLD_LAST) begin
          tcnt_d  = '0;
          state_d = db ? RUN : WAIT_REL;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      WAIT_REL: begin
        if (db) state_d = RUN;
      end
      default: state_d = POR;
    endcase
  end

  // resetn is a flop copy of "next state is RUN" so it is glitch-free.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q   <= POR;
      tcnt_q    <= '0;
      rc_q      <= '0;
      db_prev_q <= 1'b1;
      resetn_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      rc_q      <= rc_d;
      db_prev_q <= db;
      resetn_q  <= (state_d == RUN);
    end
  end

  assign resetn      = resetn_q;
  assign key_db      = db;
  assign reset_count = rc_q;

endmodule
